// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with rx_done synchroniser, status flags and threshold interrupt
//
// Purpose: takes bytes completed by the UART receiver (rx_done pulse, tick
// domain), synchronises the pulse into clk, and stores the bytes in a
// first-word-fall-through FIFO that the bus logic reads.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx_data    received byte, stable while rx_done is high (and a bit after)
//   rx_done    byte-complete flag, asynchronous to clk
//   rd_en      pop the head byte (ignored when empty)
//   clr_ovr    clear the sticky overrun flag
//   irq_en     interrupt enable
//   rx_thresh  fill threshold for irq (0 behaves as 1)
//   rd_data    head byte, 8'h00 when empty
//   empty      count == 0
//   full       count == DEPTH
//   count      stored bytes, 0..DEPTH
//   overrun    sticky: a byte was dropped because the FIFO was full
//   irq        registered irq_en & ((count >= threshold) | overrun)
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          rd_en,
  input  logic          clr_ovr,
  input  logic          irq_en,
  input  logic [AW:0]   rx_thresh,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          irq
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic          s1, s2, s3;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt_q;

  logic          push;
  logic          do_pop;
  logic          accept;
  logic          drop;
  logic [AW:0]   eff_thresh;

  // s1/s2 resynchronise the asynchronous flag, s3 remembers the previous
  // synchronised level so a long rx_done still yields a single push.
  assign push   = s2 & ~s3;
  assign do_pop = rd_en & (cnt_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // only dropped when nothing is being read out.
  assign accept = push & ((cnt_q != DEPTH_C) | do_pop);
  assign drop   = push & (cnt_q == DEPTH_C) & ~do_pop;

  assign eff_thresh = (rx_thresh == '0) ? ONE_C : rx_thresh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      overrun <= 1'b0;
      irq     <= 1'b0;
    end else begin
      s1 <= rx_done;
      s2 <= s1;
      s3 <= s2;

      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;

      if (accept && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !accept) cnt_q <= cnt_q - 1'b1;

      // Set has priority over clear so a drop is never lost.
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;

      // Built from the registered count/overrun, so irq trails them by one edge.
      irq <= irq_en & ((cnt_q >= eff_thresh) | overrun);
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= rx_data;
  end

  assign count   = cnt_q;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_C);
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_ovr = 1'b0;
  logic        irq_en = 1'b0;
  logic [AW:0] rx_thresh = '0;
  logic [7:0]  rd_data;
  logic        empty, full, overrun, irq;
  logic [AW:0] count;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] sb[$];
  logic       mdl_ovr = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .rd_en(rd_en), .clr_ovr(clr_ovr), .irq_en(irq_en), .rx_thresh(rx_thresh),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  // Push one byte; rd_en/clr_ovr are asserted only in the cycle the push lands.
  task automatic push_ex(input logic [7:0] b, input logic rd, input logic clr, input string nm);
    logic dropped;
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (rd && sb.size() > 0) begin
      n_total++;
      if (rd_data !== sb[0]) $display("FAIL %s head got %h exp %h", nm, rd_data, sb[0]);
      else n_pass++;
      void'(sb.pop_front());
    end
    rd_en   = rd;
    clr_ovr = clr;
    @(negedge clk);
    rd_en   = 1'b0;
    clr_ovr = 1'b0;
    dropped = (sb.size() >= DEPTH);
    if (!dropped) sb.push_back(b);
    if (dropped) mdl_ovr = 1'b1;
    else if (clr) mdl_ovr = 1'b0;
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (count !== (AW+1)'(sb.size())) $display("FAIL %s count got %0d exp %0d", nm, count, sb.size());
    else n_pass++;
    n_total++;
    if (overrun !== mdl_ovr) $display("FAIL %s overrun got %b exp %b", nm, overrun, mdl_ovr);
    else n_pass++;
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_ex(b, 1'b0, 1'b0, "push");
  endtask

  task automatic pop_one(input string nm);
    logic [7:0] exp;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL %s pop got empty_model exp data", nm);
    end else begin
      exp = sb.pop_front();
      if (rd_data !== exp) $display("FAIL %s data got %h exp %h", nm, rd_data, exp);
      else n_pass++;
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic drain(input string nm);
    while (sb.size() > 0) pop_one(nm);
    n_total++;
    if (empty !== 1'b1 || rd_data !== 8'h00) $display("FAIL %s drain empty got %b/%h exp 1/00", nm, empty, rd_data);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (empty !== 1'b1 || count !== '0 || rd_data !== 8'h00 || full !== 1'b0 || overrun !== 1'b0 || irq !== 1'b0)
      $display("FAIL reset got e%b c%0d d%h f%b o%b i%b exp e1 c0 d00 f0 o0 i0", empty, count, rd_data, full, overrun, irq);
    else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    rx_data = 8'hA5;
    rx_done = 1'b1;
    @(negedge clk);
    n_total++;
    if (empty !== 1'b1) $display("FAIL single_e0 empty got %b exp 1", empty); else n_pass++;
    @(negedge clk);
    n_total++;
    if (empty !== 1'b1) $display("FAIL single_e1 empty got %b exp 1", empty); else n_pass++;
    @(negedge clk);
    n_total++;
    if (empty !== 1'b0 || rd_data !== 8'hA5) $display("FAIL single_e2 got e%b d%h exp e0 dA5", empty, rd_data);
    else n_pass++;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (count !== 5'd1) $display("FAIL single_count got %0d exp 1", count); else n_pass++;
    sb.push_back(8'hA5);
    pop_one("single_pop");
    n_total++;
    if (empty !== 1'b1 || rd_data !== 8'h00) $display("FAIL single_after_pop got e%b d%h exp e1 d00", empty, rd_data);
    else n_pass++;
  endtask

  task automatic fill_seq();
    for (int i = 1; i <= DEPTH; i++) push_byte(8'(i));
  endtask

  task automatic test_fill_order();
    for (int r = 0; r < 3; r++) begin
      fill_seq();
      n_total++;
      if (full !== 1'b1 || count !== 5'd16) $display("FAIL fill_full got f%b c%0d exp f1 c16", full, count);
      else n_pass++;
      drain("fill_order");
    end
  endtask

  task automatic test_overrun();
    fill_seq();
    push_ex(8'hEE, 1'b0, 1'b0, "ovr_drop");
    n_total++;
    if (overrun !== 1'b1 || rd_data !== 8'h01 || count !== 5'd16)
      $display("FAIL ovr_state got o%b d%h c%0d exp o1 d01 c16", overrun, rd_data, count);
    else n_pass++;
    push_ex(8'hEF, 1'b0, 1'b1, "ovr_clr_vs_set");
    n_total++;
    if (overrun !== 1'b1) $display("FAIL ovr_set_wins got %b exp 1", overrun); else n_pass++;
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    mdl_ovr = 1'b0;
    n_total++;
    if (overrun !== 1'b0) $display("FAIL ovr_clear got %b exp 0", overrun); else n_pass++;
  endtask

  task automatic test_simultaneous();
    push_ex(8'h77, 1'b1, 1'b0, "simul_full");
    n_total++;
    if (count !== 5'd16 || overrun !== 1'b0) $display("FAIL simul_full_flags got c%0d o%b exp c16 o0", count, overrun);
    else n_pass++;
    n_total++;
    if (sb[DEPTH-1] !== 8'h77) $display("FAIL simul_model_tail got %h exp 77", sb[DEPTH-1]); else n_pass++;
    drain("simul_drain");
    push_ex(8'h55, 1'b1, 1'b0, "simul_empty");
    n_total++;
    if (count !== 5'd1) $display("FAIL simul_empty_count got %0d exp 1", count); else n_pass++;
    drain("simul_empty_drain");
  endtask

  task automatic test_irq();
    irq_en = 1'b1;
    rx_thresh = 5'd3;
    push_byte(8'h10);
    push_byte(8'h11);
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_below got %b exp 0", irq); else n_pass++;
    rx_data = 8'h12;
    rx_done = 1'b1;
    repeat (3) @(negedge clk);
    sb.push_back(8'h12);
    n_total++;
    if (count !== 5'd3 || irq !== 1'b0) $display("FAIL irq_lat0 got c%0d i%b exp c3 i0", count, irq); else n_pass++;
    @(negedge clk);
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_lat1 got %b exp 1", irq); else n_pass++;
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
    pop_one("irq_pop");
    @(negedge clk);
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_after_pop got %b exp 0", irq); else n_pass++;
    drain("irq_drain");
    rx_thresh = '0;
    push_byte(8'h20);
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_thresh0 got %b exp 1", irq); else n_pass++;
    irq_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_byte(8'(8'h30 + i));
      n_total++;
      if (irq !== 1'b0) $display("FAIL irq_disabled got %b exp 0", irq); else n_pass++;
    end
    drain("irq_dis_drain");
  endtask

  task automatic test_async_reset();
    irq_en = 1'b1;
    rx_thresh = 5'd1;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i));
    n_total++;
    if (irq !== 1'b1 || count !== 5'd5) $display("FAIL arst_pre got i%b c%0d exp i1 c5", irq, count); else n_pass++;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if (empty !== 1'b1 || count !== '0 || rd_data !== 8'h00 || full !== 1'b0 || overrun !== 1'b0 || irq !== 1'b0)
      $display("FAIL arst_immediate got e%b c%0d d%h f%b o%b i%b exp e1 c0 d00 f0 o0 i0", empty, count, rd_data, full, overrun, irq);
    else n_pass++;
    sb.delete();
    mdl_ovr = 1'b0;
    irq_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_byte(8'h3C);
    drain("arst_after");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_order();
    test_overrun();
    test_simultaneous();
    test_irq();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
